// File: rtl/aes_key_expand.sv
// Iterative AES-128 key schedule: emits round keys 0..10 over valid/ready,
// computing each next key from the single held key register.
//
// state | meaning
// IDLE  | waiting for start; key sampled on the accepting edge
// EMIT  | rk/rk_idx valid, advance on each handshake
// DONE  | one-cycle done pulse, then back to IDLE
module aes_key_expand #(
    parameter int NR = 10
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [127:0] key,
    input  logic         rk_ready,
    output logic         rk_valid,
    output logic [127:0] rk,
    output logic [3:0]   rk_idx,
    output logic         busy,
    output logic         done
);

    if (NR != 10) begin : g_nr_check
        $error("aes_key_expand: only NR=10 (AES-128) is supported");
    end

    localparam logic [3:0] LAST_IDX = 4'(NR);

    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EMIT = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t       state_q;
    logic [127:0] rk_q;
    logic [127:0] rk_d;
    logic [3:0]   idx_q;
    logic [7:0]   rcon_q;
    logic [7:0]   rcon_d;
    logic         valid_q;
    logic         busy_q;
    logic         done_q;

    logic [31:0]  rot_w;
    logic [31:0]  t_w;
    logic [31:0]  w0_n;
    logic [31:0]  w1_n;
    logic [31:0]  w2_n;
    logic [31:0]  w3_n;

    always_comb begin
        rot_w  = {rk_q[23:0], rk_q[31:24]};
        t_w    = {SBOX[rot_w[31:24]], SBOX[rot_w[23:16]],
                  SBOX[rot_w[15:8]],  SBOX[rot_w[7:0]]} ^ {rcon_q, 24'h0};
        w0_n   = rk_q[127:96] ^ t_w;
        w1_n   = rk_q[95:64]  ^ w0_n;
        w2_n   = rk_q[63:32]  ^ w1_n;
        w3_n   = rk_q[31:0]   ^ w2_n;
        rk_d   = {w0_n, w1_n, w2_n, w3_n};
        rcon_d = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            rk_q    <= '0;
            idx_q   <= '0;
            rcon_q  <= 8'h01;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        rk_q    <= key;
                        idx_q   <= '0;
                        rcon_q  <= 8'h01;
                        valid_q <= 1'b1;
                        busy_q  <= 1'b1;
                        state_q <= EMIT;
                    end
                end
                EMIT: begin
                    if (valid_q && rk_ready) begin
                        if (idx_q == LAST_IDX) begin
                            // rk keeps the final round key after the last handshake
                            valid_q <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end else begin
                            rk_q   <= rk_d;
                            idx_q  <= idx_q + 4'd1;
                            rcon_q <= rcon_d;
                        end
                    end
                end
                DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    valid_q <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign rk_valid = valid_q;
    assign rk       = rk_q;
    assign rk_idx   = idx_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: doc/aes_key_expand.md
Name: aes_key_expand

Overview:
- Iterative AES-128 key-schedule generator that feeds round keys to the AES core, one 128-bit round key per handshake.
- Sits between the SPI-loaded key register and the round datapath of the core. It removes the need to hold all 11 round keys, 1408 bits, in flops.
- Emits round keys 0..10 in order over a valid/ready interface, then pulses done.

Parameters:
- NR, 10, number of rounds. Only 10 (AES-128) is legal; any other value is an elaboration error.

Ports:
- clk  input  1  system clock, all logic on rising edge
- reset  input  1  synchronous, active-low reset (0 = reset)
- start  input  1  request expansion of key; sampled only in IDLE
- key  input  128  cipher key; key[127:120] is byte 0, w0 = key[127:96], w3 = key[31:0]
- rk_ready  input  1  consumer accepts rk this cycle
- rk_valid  output  1  rk/rk_idx hold a valid round key
- rk  output  128  current round key, same byte order as key
- rk_idx  output  4  round number of rk, 0..10
- busy  output  1  high whenever state != IDLE
- done  output  1  one-cycle pulse after round key 10 is accepted

Behaviour:
- Reset (reset==0 at a clock edge):
  - State goes to IDLE.
  - rk_valid=0, rk=0, rk_idx=0, busy=0, done=0, rcon=8'h01.
  - Reset wins over all other inputs. Reset mid-expansion abandons the sequence with no done pulse.
- States: IDLE, EMIT, DONE.
- IDLE:
  - If start=1 at edge T: register rk<=key, rk_idx<=0, rcon<=01, rk_valid<=1, go to EMIT. rk is valid from T+1.
  - If start=0, stay in IDLE.
- EMIT:
  - rk, rk_idx and rk_valid are held stable while rk_ready=0, for any number of cycles.
  - Handshake (rk_valid & rk_ready) with rk_idx<10: rk<=next(rk), rk_idx<=rk_idx+1, rcon<=xtime(rcon), rk_valid stays 1.
  - Handshake with rk_idx==10: rk_valid<=0, go to DONE. rk keeps its last value.
- DONE: done=1 for exactly this cycle, then go to IDLE unconditionally.
- start is ignored in EMIT and DONE. key is sampled only at the accepting edge; later changes to key have no effect on the sequence in flight.
- Back-to-back: start in the first IDLE cycle after DONE is accepted normally.
- Latency with rk_ready tied high:
  - rk_idx 0..10 valid on cycles T+1..T+11, one per cycle.
  - done=1 at T+12; busy=1 on T+1..T+12.
- next(rk):
  - Split rk into w0..w3, with w0 the most significant word.
  - t = SubWord(RotWord(w3)) ^ {rcon,24'h0}, where RotWord(w)={w[23:0],w[31:24]}.
  - w0'=w0^t, w1'=w1^w0', w2'=w2^w1', w3'=w3^w2'.
- SubWord: four parallel combinational lookups in the FIPS-197 forward S-box, 256x8 constant table inside this block.
- rcon sequence: 01,02,04,08,10,20,40,80,1b,36.
  - xtime(x) = {x[6:0],1'b0} ^ (x[7] ? 8'h1b : 8'h00).
  - rcon used to form round i is the value for i, i=1..10.
- Only one expansion is in flight at a time. There is no internal buffering beyond the single rk register.

Test Plan:
- FIPS-197 A.1: key=2b7e151628aed2a6abf7158809cf4f3c, start pulse, rk_ready=1 -> rk_idx 0 = key; rk_idx 1 = a0fafe1788542cb123a339392a6c7605; rk_idx 10 = d014f9a8c9ee2589e13f0cc8b6630ca6; 11 consecutive valid cycles; done at T+12 for 1 cycle.
- Zero key, rk_ready=1 -> rk_idx 1 = 62636363626363636263636362636363; rk_idx 10 = b4ef5bcb3e92e21123e951cf6f8f188e.
- Backpressure:
  - Stimulus: A.1 key, with rk_ready toggled randomly (including 5-cycle low runs).
  - Required: rk/rk_idx stable while rk_ready=0; the accepted sequence matches the A.1 round-key sequence exactly; done only after the idx-10 handshake.
- Ignored inputs: start re-asserted and key changed to all-ones mid-expansion -> sequence unchanged, and busy stays high until after done.
- Reset mid-operation: reset=0 for 1 cycle after the rk_idx 4 handshake -> next cycle rk_valid=0, busy=0, done=0, and no done pulse follows. Then start with the zero key -> correct zero-key sequence from idx 0, confirming rcon restarts at 01.
- Back-to-back: start asserted continuously -> second expansion accepted in the IDLE cycle right after DONE, with rk_valid again 1 cycle later.
